// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap sequencer.
// Optional saturation is selected with the FIR_SAT_EN macro (see fir_mac_unit).
package fir_pkg;

  localparam int unsigned IN_BITS        = 16;
  localparam int unsigned COEF_BITS      = 16;
  localparam int unsigned OUT_BITS       = 16;
  localparam int unsigned COUNTER_BITS   = 6;
  localparam int unsigned NUMBER_OF_TAPS = 64;
  localparam int unsigned OUT_SHIFT      = 15;

  // Wide enough that summing NUMBER_OF_TAPS full-scale products cannot overflow.
  localparam int unsigned ACC_BITS = IN_BITS + COEF_BITS + COUNTER_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StMac,
    StOut
  } fir_state_e;

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with round-half-up, arithmetic shift and narrowing.
// FIR_SAT_EN defined: the narrowed result saturates and a clipped indication is produced.
// FIR_SAT_EN undefined: the narrowed result wraps (low OUT_BITS bits kept).
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        enable,
  input  logic signed [IN_BITS-1:0]   tap_data,
  input  logic signed [COEF_BITS-1:0] coef_data,
`ifdef FIR_SAT_EN
  output logic                        clipped,
`endif
  output logic signed [OUT_BITS-1:0]  result
);

  localparam int unsigned ProdBits = IN_BITS + COEF_BITS;
  localparam logic signed [ACC_BITS:0] RoundBias = (ACC_BITS + 1)'(1) <<< (OUT_SHIFT - 1);

  logic signed [ProdBits-1:0] tap_ext;
  logic signed [ProdBits-1:0] coef_ext;
  logic signed [ProdBits-1:0] product;
  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_sum;
  logic signed [ACC_BITS:0]   rounded;
  logic signed [ACC_BITS:0]   shifted;

  assign tap_ext  = ProdBits'(tap_data);
  assign coef_ext = ProdBits'(coef_data);
  assign product  = tap_ext * coef_ext;
  // The sum including the current product, so the last tap is folded into the result.
  assign acc_sum  = acc_q + ACC_BITS'(product);
  assign rounded  = (ACC_BITS + 1)'(acc_sum) + RoundBias;
  assign shifted  = rounded >>> OUT_SHIFT;

  // Accumulator: cleared at the start of a sweep, advanced once per tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_sum;
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_BITS:0] OutMax = (ACC_BITS + 1)'((1 <<< (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS:0] OutMin = ~OutMax;

  // Clamp the shifted sum into the signed output range.
  always_comb begin
    result  = shifted[OUT_BITS-1:0];
    clipped = 1'b0;
    if (shifted > OutMax) begin
      result  = OutMax[OUT_BITS-1:0];
      clipped = 1'b1;
    end else if (shifted < OutMin) begin
      result  = OutMin[OUT_BITS-1:0];
      clipped = 1'b1;
    end
  end
`else
  logic unused_shifted;

  // Two's-complement wrap: keep only the low output bits.
  always_comb begin
    result = shifted[OUT_BITS-1:0];
  end

  assign unused_shifted = ^shifted[ACC_BITS:OUT_BITS];
`endif

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: input handshake, delay-line launch strobe, tap sweep and output handshake.
// FIR_SAT_EN adds the sticky sat_flag output and saturating narrowing in fir_mac_unit.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [IN_BITS-1:0]      in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           phase_min,
  output logic signed [IN_BITS-1:0]      pipe_din,
  output logic        [COUNTER_BITS-1:0] current_count,
  input  logic signed [IN_BITS-1:0]      tap_data,
  output logic        [COUNTER_BITS-1:0] coef_addr,
  input  logic signed [COEF_BITS-1:0]    coef_data,
  output logic signed [OUT_BITS-1:0]     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef FIR_SAT_EN
  output logic                           sat_flag,
`endif
  output logic                           busy
);

  localparam logic [COUNTER_BITS-1:0] LastTap = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

  fir_state_e                    state_q, state_d;
  logic                          in_ready_q, in_ready_d;
  logic                          phase_min_q, phase_min_d;
  logic signed [IN_BITS-1:0]     pipe_din_q, pipe_din_d;
  logic        [COUNTER_BITS-1:0] count_q, count_d;
  logic signed [OUT_BITS-1:0]    out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          busy_q, busy_d;
  logic                          mac_clear;
  logic                          mac_enable;
  logic signed [OUT_BITS-1:0]    mac_result;
`ifdef FIR_SAT_EN
  logic                          mac_clipped;
  logic                          sat_flag_q, sat_flag_d;
`endif

  fir_mac_unit u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (mac_clear),
    .enable    (mac_enable),
    .tap_data  (tap_data),
    .coef_data (coef_data),
`ifdef FIR_SAT_EN
    .clipped   (mac_clipped),
`endif
    .result    (mac_result)
  );

  // Next-state and registered-output logic for the IDLE/LOAD/MAC/OUT sequence.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    phase_min_d = phase_min_q;
    pipe_din_d  = pipe_din_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mac_clear   = 1'b0;
    mac_enable  = 1'b0;
`ifdef FIR_SAT_EN
    sat_flag_d  = sat_flag_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        // Only an edge where in_ready is already visible upstream completes a handshake.
        if (in_valid && in_ready_q) begin
          pipe_din_d  = in_data;
          phase_min_d = 1'b1;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        phase_min_d = 1'b0;
        mac_clear   = 1'b1;
        count_d     = '0;
        state_d     = StMac;
      end
      StMac: begin
        mac_enable = 1'b1;
        if (count_q == LastTap) begin
          out_data_d  = mac_result;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StOut;
`ifdef FIR_SAT_EN
          sat_flag_d  = sat_flag_q | mac_clipped;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          count_d     = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      phase_min_q <= 1'b0;
      pipe_din_q  <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIR_SAT_EN
      sat_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      phase_min_q <= phase_min_d;
      pipe_din_q  <= pipe_din_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef FIR_SAT_EN
      sat_flag_q  <= sat_flag_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign phase_min     = phase_min_q;
  assign pipe_din      = pipe_din_q;
  assign current_count = count_q;
  assign coef_addr     = count_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
`ifdef FIR_SAT_EN
  assign sat_flag      = sat_flag_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a behavioural delay line and coefficient ROM.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  logic signed [IN_BITS-1:0]      in_data = '0;
  logic                           in_valid = 1'b0;
  logic                           in_ready;
  logic                           phase_min;
  logic signed [IN_BITS-1:0]      pipe_din;
  logic        [COUNTER_BITS-1:0] current_count;
  logic signed [IN_BITS-1:0]      tap_data;
  logic        [COUNTER_BITS-1:0] coef_addr;
  logic signed [COEF_BITS-1:0]    coef_data;
  logic signed [OUT_BITS-1:0]     out_data;
  logic                           out_valid;
  logic                           out_ready = 1'b0;
  logic                           busy;
`ifdef FIR_SAT_EN
  logic                           sat_flag;
`endif

  fir_tap_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .phase_min     (phase_min),
    .pipe_din      (pipe_din),
    .current_count (current_count),
    .tap_data      (tap_data),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
`ifdef FIR_SAT_EN
    .sat_flag      (sat_flag),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Delay line and coefficient ROM models.
  logic signed [IN_BITS-1:0]   dl   [NUMBER_OF_TAPS];
  logic signed [COEF_BITS-1:0] coef [NUMBER_OF_TAPS];
  assign tap_data  = dl[current_count];
  assign coef_data = coef[coef_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMBER_OF_TAPS; i++) dl[i] <= '0;
    end else if (phase_min) begin
      dl[0] <= pipe_din;
      for (int i = 1; i < NUMBER_OF_TAPS; i++) dl[i] <= dl[i-1];
    end
  end

  int cycle = 0;
  int max_cnt = 0;
  int pm_run = 0;
  int pm_max = 0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(current_count) > max_cnt) max_cnt <= int'(current_count);
      pm_run <= phase_min ? pm_run + 1 : 0;
      if (phase_min && (pm_run + 1 > pm_max)) pm_max <= pm_run + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  int ref_line [NUMBER_OF_TAPS];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_out();
    longint sum = 0;
    longint r;
    logic signed [OUT_BITS-1:0] t;
    for (int k = 0; k < NUMBER_OF_TAPS; k++) sum += longint'(ref_line[k]) * longint'(coef[k]);
    r = (sum + 16384) >>> 15;
`ifdef FIR_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    t = r[15:0];
    return longint'(t);
  endfunction

  task automatic push_ref(input int d);
    for (int k = NUMBER_OF_TAPS - 1; k > 0; k--) ref_line[k] = ref_line[k-1];
    ref_line[0] = d;
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NUMBER_OF_TAPS; k++) ref_line[k] = 0;
  endtask

  task automatic set_coefs_zero();
    for (int k = 0; k < NUMBER_OF_TAPS; k++) coef[k] = '0;
  endtask

  // Offer a sample; returns #1 after the accepting edge.
  task automatic feed(input logic signed [IN_BITS-1:0] d);
    int n = 0;
    bit ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (n < 300) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", longint'(in_ready), 1);
    else push_ref(int'(d));
  endtask

  task automatic get_out(input bit consume, output logic signed [OUT_BITS-1:0] d,
                         output int edges);
    edges = 0;
    while (!out_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) check("out_timeout", longint'(out_valid), 1);
    d = out_data;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic signed [COEF_BITS-1:0] c0;
    logic signed [IN_BITS-1:0]   din;
    logic signed [OUT_BITS-1:0]  exp;
  } vec_t;

  vec_t vecs [7];
  logic signed [IN_BITS-1:0] b2b_samples [8];

  initial begin
    logic signed [OUT_BITS-1:0] d, d0;
    int e;
    int pm_a, pm_b;
    int bad;

    // Hand-computed single-tap vectors: round-half-up of din*c0/32768.
    vecs[0] = '{c0: 16'sd16384,  din: 16'sd1000,  exp: 16'sd500};
    vecs[1] = '{c0: 16'sd16384,  din: -16'sd1000, exp: -16'sd500};
    vecs[2] = '{c0: 16'sd32767,  din: 16'sd1,     exp: 16'sd1};
    vecs[3] = '{c0: 16'sd16384,  din: 16'sd1,     exp: 16'sd1};
    vecs[4] = '{c0: 16'sd16384,  din: -16'sd1,    exp: 16'sd0};
    vecs[5] = '{c0: -16'sd32768, din: 16'sd3,     exp: -16'sd3};
    vecs[6] = '{c0: 16'sd16384,  din: 16'sd3,     exp: 16'sd2};

    b2b_samples = '{16'sd1000, -16'sd2000, 16'sd3000, 16'sd32767,
                    -16'sd32768, 16'sd5, -16'sd7, 16'sd12345};

    set_coefs_zero();

    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_phase_min", phase_min, 0);
    check("rst_pipe_din", pipe_din, 0);
    check("rst_count", current_count, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
`ifdef FIR_SAT_EN
    check("rst_sat_flag", sat_flag, 0);
`endif
    reset_dut();
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", in_ready, 1);

    // Table-driven single-sample vectors.
    for (int i = 0; i < 7; i++) begin
      reset_dut();
      set_coefs_zero();
      coef[0] = vecs[i].c0;
      feed(vecs[i].din);
      pm_a = int'(phase_min);
      check("vec_pipe_din", pipe_din, vecs[i].din);
      check("vec_busy", busy, 1);
      @(posedge clk); #1;
      pm_b = int'(phase_min);
      check("vec_phase_pulse", pm_a * 2 + pm_b, 2);
      get_out(1'b1, d, e);
      check("vec_out_data", d, vecs[i].exp);
      check("vec_latency", e + 1, NUMBER_OF_TAPS + 1);
    end

    // Impulse response with coef[k] = k*64: output n is 64*n.
    reset_dut();
    for (int k = 0; k < NUMBER_OF_TAPS; k++) coef[k] = 16'(k * 64);
    for (int n = 0; n < NUMBER_OF_TAPS; n++) begin
      feed((n == 0) ? 16'sd32767 : 16'sd0);
      get_out(1'b1, d, e);
      check("impulse", d, 64 * n);
    end

    // Full-scale saturation.
    reset_dut();
    for (int k = 0; k < NUMBER_OF_TAPS; k++) coef[k] = 16'sd32767;
    for (int n = 0; n < NUMBER_OF_TAPS; n++) begin
      feed(16'sd32767);
      get_out(1'b1, d, e);
    end
`ifdef FIR_SAT_EN
    check("sat_out", d, 32767);
    check("sat_flag", sat_flag, 1);
`else
    check("wrap_out", d, -128);
`endif

    // Backpressure: output held, pending input refused, accept one edge after release.
    reset_dut();
    set_coefs_zero();
    coef[0] = 16'sd16384;
    feed(16'sd200);
    get_out(1'b0, d0, e);
    check("bp_first", d0, 100);
    in_data  = 16'sd77;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_data != d0 || !out_valid || in_ready || phase_min) bad++;
    end
    check("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_not_yet", phase_min, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept", phase_min, 1);
    push_ref(77);
    get_out(1'b1, d, e);
    check("bp_second", d, 39);

    // Reset during MAC discards the partial sum and the delay-line contents.
    reset_dut();
    set_coefs_zero();
    coef[0] = 16'sd16384;
    coef[1] = 16'sd16384;
    feed(16'sd1000);
    get_out(1'b1, d, e);
    check("abort_pre", d, 500);
    feed(16'sd2000);
    e = 0;
    while (!(busy && current_count == 20) && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    check("abort_reached", current_count, 20);
    #2 rst = 1'b1;
    #1;
    check("abort_out_data", out_data, 0);
    check("abort_count", current_count, 0);
    check("abort_busy", busy, 0);
    check("abort_pipe_din", pipe_din, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NUMBER_OF_TAPS; k++) ref_line[k] = 0;
    check("abort_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("abort_ready_next", in_ready, 1);
    feed(16'sd600);
    get_out(1'b1, d, e);
    check("abort_next_out", d, 300);

    // Back-to-back with in_valid and out_ready held high.
    begin
      int acc_cyc [8];
      longint exp_q [$];
      int idx = 0;
      int n_out = 0;
      int exp_cnt = 0;
      int sweep_bad = 0;
      bit sweeping = 1'b0;
      reset_dut();
      for (int k = 0; k < NUMBER_OF_TAPS; k++) coef[k] = 16'(k * 64 - 1000);
      out_ready = 1'b1;
      in_data   = b2b_samples[0];
      in_valid  = 1'b1;
      for (int c = 0; c < 8 * 67 + 200 && n_out < 8; c++) begin
        @(posedge clk); #1;
        if (sweeping) begin
          if (int'(current_count) != exp_cnt) sweep_bad++;
          exp_cnt++;
          if (exp_cnt == NUMBER_OF_TAPS) sweeping = 1'b0;
        end
        if (phase_min) begin
          acc_cyc[idx] = cycle;
          push_ref(int'(b2b_samples[idx]));
          exp_q.push_back(model_out());
          idx++;
          if (idx < 8) in_data = b2b_samples[idx];
          else in_valid = 1'b0;
          sweeping = 1'b1;
          exp_cnt  = 0;
        end
        if (out_valid) begin
          if (exp_q.size() > 0) check("b2b_out", out_data, exp_q.pop_front());
          else check("b2b_spurious", out_valid, 0);
          n_out++;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", n_out, 8);
      for (int i = 1; i < 8; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 67);
      check("b2b_sweep", sweep_bad, 0);
    end

    check("count_max", max_cnt, NUMBER_OF_TAPS - 1);
    check("phase_min_width", pm_max, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Control and MAC sequencer for the audio-effect FIR tap delay line.
- Accepts one input sample per valid/ready handshake and launches it into the tap delay line with a one-cycle phase_min pulse.
- Sweeps current_count over all taps, accumulating tap sample × coefficient.
- Presents one rounded output sample per input, with valid/ready backpressure.
- Sits between the upstream audio source, the tap delay line and coefficient ROM, and the downstream effect stage.

Parameters:
- IN_BITS, 16: input/tap sample width, signed.
- COEF_BITS, 16: coefficient width, signed Q1.15.
- OUT_BITS, 16: output sample width, signed.
- COUNTER_BITS, 6: width of current_count and coef_addr.
- NUMBER_OF_TAPS, 64: taps swept per sample; must be in 1..2^COUNTER_BITS.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output; must be ≥1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, IN_BITS: new sample, signed.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: sequencer can accept a sample.
- phase_min, output, 1: one-cycle shift strobe to the delay line.
- pipe_din, output, IN_BITS: registered sample to the delay line input.
- current_count, output, COUNTER_BITS: tap select to the delay line.
- tap_data, input, IN_BITS: delay line output at current_count; combinational, same cycle.
- coef_addr, output, COUNTER_BITS: coefficient ROM address; always equals current_count.
- coef_data, input, COEF_BITS: coefficient at coef_addr; combinational, same cycle.
- out_data, output, OUT_BITS: filtered sample, signed.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts out_data.
- busy, output, 1: high in LOAD or MAC.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs are registered and reset to 0: in_ready, phase_min, pipe_din, current_count, out_data, out_valid, busy. The accumulator resets to 0 and state resets to IDLE. in_ready rises on the first clk edge after rst deasserts.
- IDLE: in_ready=1.
  - If in_valid at an edge: pipe_din<=in_data, phase_min<=1, in_ready<=0, go to LOAD.
- LOAD: exactly one cycle, phase_min=1; the delay line shifts at the next edge.
  - Next edge: phase_min<=0, acc<=0, current_count<=0, go to MAC.
- MAC: each edge, acc <= acc + tap_data*coef_data, using a signed product of IN_BITS+COEF_BITS bits.
  - ACC_BITS = IN_BITS+COEF_BITS+COUNTER_BITS; no accumulator overflow is possible.
  - If current_count==NUMBER_OF_TAPS-1: compute result from the final sum, out_data<=result, out_valid<=1, go to OUT. Otherwise current_count++.
- Result: (acc_final + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, then narrowed to OUT_BITS (see Optional Feature).
- OUT: out_valid and out_data held stable while out_ready=0.
  - Edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE. current_count returns to 0.
- Latency: out_valid rises NUMBER_OF_TAPS+1 edges after the accepting edge.
  - Throughput with out_ready tied high: one sample per NUMBER_OF_TAPS+3 cycles.
- Boundary conditions:
  - NUMBER_OF_TAPS=1: MAC lasts one cycle.
  - in_valid while not in IDLE is ignored (in_ready=0); upstream holds its data.
  - out_ready high when out_valid=0 has no effect.
  - rst mid-LOAD/MAC/OUT aborts immediately: partial sum discarded, no out_valid. The delay line shares rst.
  - current_count never exceeds NUMBER_OF_TAPS-1.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: the shifted result saturates to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. A sticky output sat_flag (1 bit, reset 0) sets on any clipped sample and clears on reset only.
- Undefined: the result is truncated to its low OUT_BITS bits (two's-complement wrap), and the sat_flag port is absent.

Decomposition:
- Shared package fir_pkg holds:
  - width constants IN_BITS, COEF_BITS, OUT_BITS, COUNTER_BITS, NUMBER_OF_TAPS, OUT_SHIFT;
  - derived ACC_BITS;
  - state enum IDLE/LOAD/MAC/OUT.
- One natural sub-module: fir_mac_unit, containing the signed multiply, the accumulator with clear/enable, and round/shift/narrow (including FIR_SAT_EN logic).
- The FSM, handshakes and counter stay in fir_tap_sequencer.

Test Plan:
- Single sample, gain 0.5: coef[0]=16384, others 0; accept in_data=1000 → out_data=500 exactly 65 edges after acceptance; phase_min high exactly 1 cycle.
- Impulse response: coef[k]=k*64; feed 32767 then 63 zeros (all with the reference delay line model) → output n equals round(32767*n*64/32768) = n*64 minus rounding; out sample 5 = 320.
- Saturation: all coef=32767; feed 64 samples of 32767, then check the 64th output.
  - With FIR_SAT_EN: out_data=32767, sat_flag=1.
  - Without FIR_SAT_EN: out_data=-128 (0xFF80).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0, a pending in_valid is not accepted; the accept happens 1 edge after out_ready=1.
- Reset mid-MAC: assert rst at current_count=20 → all outputs 0 asynchronously; after release, in_ready=1 next edge and the next output excludes the aborted sample.
- Back-to-back: in_valid and out_ready tied high, 8 samples → accepts exactly every 67 cycles, current_count sweeps 0..63 per sample, and outputs match the golden model.
